aespp_lanes: RTL

//  AES-128 CBC-MAC post-processor for raw TRNG blocks, successor to the single-lane serial core.

---
 rtl/aespp_pkg.sv | 67 ++++++
 rtl/aespp_lanes_if.sv | 13 +
 rtl/aes_sbox_canright_l1.sv | 9 +
 rtl/aespp_sbox_lanes.sv | 30 +++
 rtl/aespp_lanes.sv | 106 ++++++++++
 5 files changed

// File: rtl/aespp_pkg.sv
// aespp_pkg: shared types, zero-key AES-128 round keys and round functions for aespp_lanes.
package aespp_pkg;
  typedef enum logic [2:0] {IDLE, SUB, SHIFT, MIX, FINAL, OUT} state_e;
  localparam logic [127:0] AESPP_RK [0:10] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Inverse as a^254 (0 maps to 0), then the FIPS-197 affine transform.
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction
endpackage

// File: rtl/aespp_lanes_if.sv
// aespp_lanes_if: entropy-collector input handshake and output-FIFO valid/read bus of aespp_lanes.
interface aespp_lanes_if #(parameter int BLOCKS_W = 4);
  logic                i_valid;
  logic [127:0]        i_dat;
  logic [BLOCKS_W-1:0] i_blocks;
  logic                o_input_consumed;
  logic [127:0]        o_dat;
  logic                o_valid;
  logic                i_read;
  logic                o_busy;
  modport master (output i_valid, i_dat, i_blocks, i_read, input o_input_consumed, o_dat, o_valid, o_busy);
  modport slave (input i_valid, i_dat, i_blocks, i_read, output o_input_consumed, o_dat, o_valid, o_busy);
endinterface

// File: rtl/aes_sbox_canright_l1.sv
// aes_sbox_canright_l1: single combinational AES forward S-box.
module aes_sbox_canright_l1
  import aespp_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  assign s_o = aes_sbox(a_i);
endmodule

// File: rtl/aespp_sbox_lanes.sv
// aespp_sbox_lanes: LANES parallel S-boxes with optional output register; valid tracks the data.
module aespp_sbox_lanes #(
  parameter int LANES = 1,
  parameter int REG   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [8*LANES-1:0] bytes_i,
  output logic               valid_o,
  output logic [8*LANES-1:0] bytes_o
);
  logic [8*LANES-1:0] sub;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_canright_l1 u_sbox (.a_i(bytes_i[8*g +: 8]), .s_o(sub[8*g +: 8]));
  end
  if (REG != 0) begin : g_reg
    logic               valid_q;
    logic [8*LANES-1:0] bytes_q;
    always_ff @(posedge clk) begin
      valid_q <= rst ? 1'b0 : valid_i;
      bytes_q <= sub;
    end
    assign valid_o = valid_q;
    assign bytes_o = bytes_q;
  end else begin : g_comb
    assign valid_o = valid_i;
    assign bytes_o = sub;
  end
endmodule

// File: rtl/aespp_lanes.sv
// aespp_lanes: AES-128 CBC-MAC post-processor for TRNG blocks with SBOX_LANES bytes/cycle SubBytes.
// AESPP_CHAIN_OUT_EN chains each output into the next MAC; undefined, every output starts from zero.
module aespp_lanes
  import aespp_pkg::*;
#(
  parameter int SBOX_LANES = 1,
  parameter int SBOX_REG   = 0,
  parameter int BLOCKS_W   = 4
) (
  input logic         i_clk,
  input logic         i_reset,
  aespp_lanes_if.slave bus
);
  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("aespp_lanes: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end
  localparam logic [3:0] STEP_LAST = 4'(16 / SBOX_LANES - 1);
`ifdef AESPP_CHAIN_OUT_EN
  localparam bit CHAIN_OUT = 1'b1;
`else
  localparam bit CHAIN_OUT = 1'b0;
`endif
  state_e                   state_q;
  logic [127:0]             st_q, chain_q, dat_q;
  logic [BLOCKS_W-1:0]      block_q, nblk_q;
  logic [3:0]               round_q, step_q;
  logic                     phase_q, valid_q, consumed_q;
  logic                     lane_in_v, lane_v;
  logic [8*SBOX_LANES-1:0]  lane_out;
  logic [127:0]             rot, fin;
  // With a registered S-box each step spends one cycle issuing and one cycle writing back.
  assign lane_in_v = (state_q == SUB) && !phase_q;
  aespp_sbox_lanes #(.LANES(SBOX_LANES), .REG(SBOX_REG)) u_lanes (
    .clk(i_clk), .rst(i_reset), .valid_i(lane_in_v), .bytes_i(st_q[8*SBOX_LANES-1:0]),
    .valid_o(lane_v), .bytes_o(lane_out)
  );
  if (SBOX_LANES == 16) begin : g_full
    assign rot = lane_out;
  end else begin : g_part
    assign rot = {lane_out, st_q[127:8*SBOX_LANES]};
  end
  assign fin = st_q ^ AESPP_RK[10];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      st_q       <= '0;
      chain_q    <= '0;
      dat_q      <= '0;
      block_q    <= '0;
      nblk_q     <= '0;
      round_q    <= '0;
      step_q     <= '0;
      phase_q    <= 1'b0;
      valid_q    <= 1'b0;
      consumed_q <= 1'b0;
    end else begin
      consumed_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.i_valid) begin
          st_q       <= bus.i_dat ^ chain_q ^ AESPP_RK[0];
          consumed_q <= 1'b1;
          round_q    <= 4'd1;
          state_q    <= SUB;
          if (block_q == '0) nblk_q <= bus.i_blocks;
        end
        SUB: begin
          phase_q <= (SBOX_REG != 0) && !phase_q;
          if (lane_v) begin
            st_q   <= rot;
            step_q <= (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
            if (step_q == STEP_LAST) state_q <= SHIFT;
          end
        end
        SHIFT: begin
          st_q    <= shift_rows(st_q);
          state_q <= (round_q == 4'd10) ? FINAL : MIX;
        end
        MIX: begin
          st_q    <= mix_columns(st_q) ^ AESPP_RK[round_q];
          round_q <= round_q + 4'd1;
          state_q <= SUB;
        end
        FINAL: if (block_q == nblk_q) begin
          dat_q   <= fin;
          valid_q <= 1'b1;
          state_q <= OUT;
        end else begin
          chain_q <= fin;
          block_q <= block_q + 1'b1;
          state_q <= IDLE;
        end
        OUT: if (bus.i_read) begin
          valid_q <= 1'b0;
          block_q <= '0;
          chain_q <= CHAIN_OUT ? dat_q : '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.o_dat            = dat_q;
  assign bus.o_valid          = valid_q;
  assign bus.o_input_consumed = consumed_q;
  assign bus.o_busy           = state_q != IDLE;
endmodule
